multicycle_seq: RTL and testbench

- Multi-cycle control sequencer for the RV32I core datapath (fetch unit, register file, ALU, data memory, write-back mux).
- Replaces single-cycle execution: steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB and generates the per-stage write enables.
- Supports variable-latency instruction and data memories through ready handshakes.
- Counts retired instructions and handles halt requests, EBREAK and illegal opcodes.

---
 rtl/seq_pkg.sv | 43 ++++
 rtl/seq_opclass_dec.sv | 25 ++
 rtl/multicycle_seq.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: state codes,
// opcode constants, the instruction-class encoding and the boundary helper.
package seq_pkg;

    localparam logic [2:0] FETCH   = 3'd0;
    localparam logic [2:0] DECODE  = 3'd1;
    localparam logic [2:0] EXECUTE = 3'd2;
    localparam logic [2:0] MEM     = 3'd3;
    localparam logic [2:0] WB      = 3'd4;
    localparam logic [2:0] HALT    = 3'd5;
    localparam logic [2:0] TRAP    = 3'd6;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_I       = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_SYS     = 4'd9,
        CLS_ILLEGAL = 4'd10
    } op_class_e;

    // Where an instruction goes once it retires.
    function automatic logic [2:0] boundary_state(input logic halt_req);
        return halt_req ? HALT : FETCH;
    endfunction

endpackage

// File: rtl/seq_opclass_dec.sv
// Combinational RV32I opcode-to-class decoder used by the sequencer.
module seq_opclass_dec
    import seq_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_e  op_class
);

    always_comb begin
        case (opcode)
            OP_R:      op_class = CLS_R;
            OP_I:      op_class = CLS_I;
            OP_LOAD:   op_class = CLS_LOAD;
            OP_STORE:  op_class = CLS_STORE;
            OP_BRANCH: op_class = CLS_BRANCH;
            OP_JAL:    op_class = CLS_JAL;
            OP_JALR:   op_class = CLS_JALR;
            OP_LUI:    op_class = CLS_LUI;
            OP_AUIPC:  op_class = CLS_AUIPC;
            OP_SYS:    op_class = CLS_SYS;
            default:   op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control sequencer for the RV32I core.
// Optional memory-wait watchdog enabled by defining MULTICYCLE_SEQ_TIMEOUT_EN.
module multicycle_seq
    import seq_pkg::*;
#(
    parameter int RESET_STATE_HALT = 0
`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES   = 256
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        halt_req,
    output logic        imem_req,
    output logic        ir_we,
    output logic        ex_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        pc_we,
    output logic [31:0] instret,
    output logic [2:0]  state_o,
    output logic        halted,
    output logic        illegal
`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
    ,
    output logic        timeout
`endif
);

    localparam logic [2:0] RESET_STATE = (RESET_STATE_HALT != 0) ? HALT : FETCH;

    logic [2:0]  state_q, state_d;
    op_class_e   class_q, class_d, dec_class;
    logic [31:0] instret_q, instret_d;
    logic        illegal_q, illegal_d;
    logic        retire;

`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    seq_opclass_dec u_dec (
        .opcode   (opcode),
        .op_class (dec_class)
    );

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        ex_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;

        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                class_d = dec_class;
                case (dec_class)
                    CLS_ILLEGAL: begin
                        state_d   = TRAP;
                        illegal_d = 1'b1;
                    end
                    CLS_SYS: state_d = HALT;
                    default: state_d = EXECUTE;
                endcase
            end
            EXECUTE: begin
                ex_we = 1'b1;
                case (class_q)
                    CLS_BRANCH: begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = boundary_state(halt_req);
                    end
                    CLS_LOAD, CLS_STORE: state_d = MEM;
                    default:             state_d = WB;
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (class_q == CLS_STORE);
                if (dmem_ready) begin
                    if (class_q == CLS_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = boundary_state(halt_req);
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = boundary_state(halt_req);
            end
            HALT: begin
                if (!halt_req) state_d = FETCH;
            end
            TRAP: state_d = TRAP;
            default: state_d = TRAP;
        endcase

`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
        // Counter only advances while stalled; any state change leaves it at zero.
        wait_cnt_d = '0;
        timeout_d  = 1'b0;
        if ((state_q == FETCH && !imem_ready) || (state_q == MEM && !dmem_ready)) begin
            if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d   = TRAP;
                timeout_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end
`endif

        instret_d = instret_q + {31'd0, retire};

        // Strobes are silenced while reset is held so nothing reaches memory mid-reset.
        if (!rst) begin
            imem_req = 1'b0;
            ir_we    = 1'b0;
            ex_we    = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            rf_we    = 1'b0;
            pc_we    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RESET_STATE;
            class_q    <= CLS_R;
            instret_q  <= '0;
            illegal_q  <= 1'b0;
`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            class_q    <= class_d;
            instret_q  <= instret_d;
            illegal_q  <= illegal_d;
`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign instret = instret_q;
    assign state_o = state_q;
    assign halted  = (state_q == HALT);
    assign illegal = illegal_q;
`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
    assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq: directed table, corner sequences and
// randomized instructions checked against a latency/enable-count model.
module tb_multicycle_seq;
    import seq_pkg::*;

    typedef struct {
        int         cycles;
        int         imreq;
        int         ir;
        int         ex;
        int         rf;
        int         pc;
        int         dreq;
        int         dwe;
        int         viol;
        logic [2:0] fin;
    } tally_t;

    typedef struct {
        logic [6:0] op;
        int         wi;
        int         wd;
        logic       hr;
        tally_t     exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic        imem_ready, dmem_ready, halt_req;
    logic        imem_req, ir_we, ex_we, dmem_req, dmem_we, rf_we, pc_we;
    logic [31:0] instret;
    logic [2:0]  state_o;
    logic        halted, illegal;
    logic        imem_req_h, ir_we_h, ex_we_h, dmem_req_h, dmem_we_h, rf_we_h, pc_we_h;
    logic [31:0] instret_h;
    logic [2:0]  state_o_h;
    logic        halted_h, illegal_h;
`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
    logic        timeout, timeout_h;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multicycle_seq #(
        .RESET_STATE_HALT (0)
`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES (8)
`endif
    ) u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .halt_req(halt_req), .imem_req(imem_req),
        .ir_we(ir_we), .ex_we(ex_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .pc_we(pc_we), .instret(instret), .state_o(state_o),
        .halted(halted), .illegal(illegal)
`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    multicycle_seq #(
        .RESET_STATE_HALT (1)
    ) u_dut_h (
        .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .halt_req(halt_req), .imem_req(imem_req_h),
        .ir_we(ir_we_h), .ex_we(ex_we_h), .dmem_req(dmem_req_h), .dmem_we(dmem_we_h),
        .rf_we(rf_we_h), .pc_we(pc_we_h), .instret(instret_h), .state_o(state_o_h),
        .halted(halted_h), .illegal(illegal_h)
`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
        , .timeout(timeout_h)
`endif
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          txn   = 0;
    logic [31:0] exp_instret = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic any_strobe();
        return imem_req | ir_we | ex_we | dmem_req | dmem_we | rf_we | pc_we;
    endfunction

    // Expected behaviour from the latency table and the per-class enable rules.
    function automatic tally_t model(input logic [6:0] op, input int wi, input int wd, input logic hr);
        tally_t m;
        m       = '{default: 0};
        m.imreq = wi + 1;
        m.ir    = 1;
        m.fin   = hr ? 3'd5 : 3'd0;
        case (op)
            7'b1110011: begin m.cycles = wi + 2; m.fin = 3'd5; end
            7'b1100011: begin m.cycles = wi + 3; m.ex = 1; m.pc = 1; end
            7'b0100011: begin
                m.cycles = wi + 4 + wd; m.ex = 1; m.pc = 1; m.dreq = wd + 1; m.dwe = wd + 1;
            end
            7'b0000011: begin
                m.cycles = wi + 5 + wd; m.ex = 1; m.rf = 1; m.pc = 1; m.dreq = wd + 1;
            end
            7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: begin
                m.cycles = wi + 4; m.ex = 1; m.rf = 1; m.pc = 1;
            end
            default: begin m.cycles = wi + 2; m.fin = 3'd6; end
        endcase
        return m;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; halt_req = 1'b0; opcode = 7'h33;
        #1;
        check("rst_state", state_o, 0);
        check("rst_strobes", any_strobe(), 0);
        check("rst_instret", instret, 0);
        check("rst_illegal", illegal, 0);
        check("rst_halted", halted, 0);
        check("rst_halt_param_state", state_o_h, 5);
        check("rst_halt_param_halted", halted_h, 1);
        @(negedge clk);
        rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
        exp_instret = '0;
    endtask

    // One instruction from FETCH to the next boundary; ready inputs stall wi/wd cycles.
    task automatic run_instr(input logic [6:0] op, input int wi, input int wd, input logic hr,
                             output tally_t t);
        int ic, dc;
        bit done;
        t = '{default: 0};
        ic = 0; dc = 0; done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            opcode     = (state_o == DECODE) ? op : 7'($urandom);
            halt_req   = hr;
            imem_ready = (ic >= wi);
            dmem_ready = (dc >= wd);
            #1;
            t.cycles++;
            if (imem_req) begin t.imreq++; ic++; end
            if (dmem_req) begin t.dreq++;  dc++; end
            if (ir_we)   t.ir++;
            if (ex_we)   t.ex++;
            if (rf_we)   t.rf++;
            if (pc_we)   t.pc++;
            if (dmem_we) t.dwe++;
            if ((pc_we && ir_we) || (rf_we && dmem_we)) t.viol++;
            @(posedge clk);
            #1;
            if (t.ir > 0 && (state_o == FETCH || state_o == HALT || state_o == TRAP)) done = 1;
        end
        if (!done) t.cycles = -1;
        t.fin = state_o;
    endtask

    task automatic finish_txn(input string tag, input logic [6:0] op, input int wi, input int wd,
                              input logic hr, input tally_t t, input tally_t m);
        int quiet;
        txn++;
        $display("txn %0d %s op=%b wi=%0d wd=%0d hr=%0d cycles=%0d/%0d final=%0d/%0d",
                 txn, tag, op, wi, wd, hr, t.cycles, m.cycles, t.fin, m.fin);
        check("cycles", t.cycles, m.cycles);
        check("imem_req_cycles", t.imreq, m.imreq);
        check("ir_we_count", t.ir, m.ir);
        check("ex_we_count", t.ex, m.ex);
        check("rf_we_count", t.rf, m.rf);
        check("pc_we_count", t.pc, m.pc);
        check("dmem_req_cycles", t.dreq, m.dreq);
        check("dmem_we_cycles", t.dwe, m.dwe);
        check("exclusivity", t.viol, 0);
        check("final_state", t.fin, m.fin);
        exp_instret += 32'(m.pc);
        check("instret", instret, exp_instret);
        if (t.fin == HALT) begin
            check("halted_in_halt", halted, 1);
            @(negedge clk);
            halt_req = 1'b0;
            @(posedge clk);
            #1;
            check("halt_exit_state", state_o, FETCH);
            check("halt_exit_halted", halted, 0);
        end else if (t.fin == TRAP) begin
            check("trap_illegal", illegal, 1);
            quiet = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                imem_ready = 1'b1; dmem_ready = 1'b1; halt_req = 1'b0; opcode = 7'($urandom);
                #1;
                if (any_strobe()) quiet++;
            end
            check("trap_no_strobes", quiet, 0);
            check("trap_sticky", {state_o, illegal}, {TRAP, 1'b1});
            do_reset();
        end
    endtask

    initial begin
        forever begin
            #200000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
        end
    end

    initial begin
        vec_t        vecs[9];
        tally_t      t;
        tally_t      m;
        logic [3:0]  add_seq[4];
        logic [6:0]  pool[10];
        logic [6:0]  op;
        bit          found;
        int          wi, wd, cnt;
        logic        hr;

        rst = 1'b0; opcode = 7'h33; imem_ready = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0;

        //            cyc imreq ir ex rf pc dreq dwe viol fin
        vecs[0] = '{7'b0110011, 0, 0, 1'b0, '{4, 1, 1, 1, 1, 1, 0, 0, 0, 3'd0}}; // ADD
        vecs[1] = '{7'b0000011, 0, 2, 1'b0, '{7, 1, 1, 1, 1, 1, 3, 0, 0, 3'd0}}; // LW, 2 waits
        vecs[2] = '{7'b0100011, 0, 0, 1'b0, '{4, 1, 1, 1, 0, 1, 1, 1, 0, 3'd0}}; // SW
        vecs[3] = '{7'b1100011, 0, 0, 1'b0, '{3, 1, 1, 1, 0, 1, 0, 0, 0, 3'd0}}; // BEQ
        vecs[4] = '{7'b1101111, 1, 0, 1'b0, '{5, 2, 1, 1, 1, 1, 0, 0, 0, 3'd0}}; // JAL, 1 fetch wait
        vecs[5] = '{7'b0110111, 0, 0, 1'b1, '{4, 1, 1, 1, 1, 1, 0, 0, 0, 3'd5}}; // LUI then halt
        vecs[6] = '{7'b1110011, 0, 0, 1'b0, '{2, 1, 1, 0, 0, 0, 0, 0, 0, 3'd5}}; // EBREAK
        vecs[7] = '{7'b0100011, 2, 1, 1'b0, '{7, 3, 1, 1, 0, 1, 2, 2, 0, 3'd0}}; // SW with waits
        vecs[8] = '{7'b1111111, 0, 0, 1'b0, '{2, 1, 1, 0, 0, 0, 0, 0, 0, 3'd6}}; // illegal 0x7F

        do_reset();

        // Cycle-exact ADD: {ir_we, ex_we, rf_we, pc_we} per cycle.
        add_seq[0] = 4'b1000; add_seq[1] = 4'b0000; add_seq[2] = 4'b0100; add_seq[3] = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            opcode = 7'b0110011; imem_ready = 1'b1; dmem_ready = 1'b1; halt_req = 1'b0;
            #1;
            check($sformatf("add_cycle%0d", c + 1), {ir_we, ex_we, rf_we, pc_we}, add_seq[c]);
        end
        @(posedge clk);
        #1;
        exp_instret += 32'd1;
        check("add_instret", instret, exp_instret);
        $display("txn %0d add_cycle_exact instret=%0d", ++txn, instret);

        for (int i = 0; i < 9; i++) begin
            run_instr(vecs[i].op, vecs[i].wi, vecs[i].wd, vecs[i].hr, t);
            finish_txn("table", vecs[i].op, vecs[i].wi, vecs[i].wd, vecs[i].hr, t, vecs[i].exp);
        end

        // halt_req raised during EXECUTE of an ADD: WB still completes, then HALT.
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            opcode = 7'b0110011; imem_ready = 1'b1; dmem_ready = 1'b1; halt_req = 1'b0;
            #1;
            if (state_o == EXECUTE) found = 1;
        end
        check("halt_seq_reach_execute", found, 1);
        halt_req = 1'b1;
        @(negedge clk);
        #1;
        check("halt_seq_wb", {state_o, rf_we, pc_we}, {WB, 1'b1, 1'b1});
        @(posedge clk);
        #1;
        check("halt_seq_halted", {state_o, halted}, {HALT, 1'b1});
        exp_instret += 32'd1;
        check("halt_seq_instret", instret, exp_instret);
        @(negedge clk);
        halt_req = 1'b0;
        @(posedge clk);
        #1;
        check("halt_seq_resume", state_o, FETCH);
        $display("txn %0d halt_during_execute state=%0d", ++txn, state_o);

        // Reset asserted while a store waits in MEM drops the request immediately.
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            opcode = 7'b0100011; imem_ready = 1'b1; dmem_ready = 1'b0; halt_req = 1'b0;
            #1;
            if (dmem_req && dmem_we) found = 1;
        end
        check("mem_rst_reach_mem", found, 1);
        #2;
        rst = 1'b0;
        #1;
        check("mem_rst_dmem_req", {dmem_req, dmem_we}, 2'b00);
        check("mem_rst_state", state_o, FETCH);
        $display("txn %0d async_reset_in_mem state=%0d dmem_req=%0d", ++txn, state_o, dmem_req);
        do_reset();

`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
        #1;
        cnt = 0;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (timeout) found = 1;
            else begin
                @(negedge clk);
                imem_ready = 1'b0;
                #1;
                cnt++;
            end
        end
        check("timeout_seen", found, 1);
        check("timeout_cycle", cnt, 8);
        check("timeout_trap", {state_o, illegal}, {TRAP, 1'b0});
        @(negedge clk);
        #1;
        check("timeout_one_pulse", timeout, 0);
        $display("txn %0d imem_timeout cycle=%0d", ++txn, cnt);
        do_reset();
`endif

        pool[0] = 7'b0110011; pool[1] = 7'b0010011; pool[2] = 7'b0000011; pool[3] = 7'b0100011;
        pool[4] = 7'b1100011; pool[5] = 7'b1101111; pool[6] = 7'b1100111; pool[7] = 7'b0110111;
        pool[8] = 7'b0010111; pool[9] = 7'b1110011;
        for (int i = 0; i < 40; i++) begin
            cnt = int'($urandom_range(0, 11));
            op  = (cnt < 10) ? pool[cnt] : 7'($urandom);
            wi  = int'($urandom_range(0, 3));
            wd  = int'($urandom_range(0, 3));
            hr  = ($urandom_range(0, 4) == 0);
            m   = model(op, wi, wd, hr);
            run_instr(op, wi, wd, hr, t);
            finish_txn("rand", op, wi, wd, hr, t, m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
